vga_gain_serializer: RTL and testbench



---
 rtl/vga_gain_serializer_if.sv | 22 ++
 rtl/vga_gain_serializer.sv | 137 +++++++++++++
 tb/tb_vga_gain_serializer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_gain_serializer_if.sv
// Gain handshake and 3-wire VGA serial bus between the AGC side and the serializer.
interface vga_gain_serializer_if;
  logic [5:0] gain_code;
  logic       gain_valid;
  logic       gain_ready;
  logic       spi_sclk;
  logic       spi_sdata;
  logic       spi_sen_n;
  logic       busy;
  logic [5:0] applied_gain;
  logic       frame_done;

  modport master (
    output gain_code, gain_valid,
    input  gain_ready, spi_sclk, spi_sdata, spi_sen_n, busy, applied_gain, frame_done
  );

  modport slave (
    input  gain_code, gain_valid,
    output gain_ready, spi_sclk, spi_sdata, spi_sen_n, busy, applied_gain, frame_done
  );
endinterface

// File: rtl/vga_gain_serializer.sv
// Maps the AGC gain code onto the three VGA stage fields and shifts them out MSB first.
// Define VGA_PARITY_EN to append an even-parity bit (17-bit frames).
module vga_gain_serializer #(
  parameter int         DIV    = 2,
  parameter logic [2:0] HEADER = 3'b101
) (
  input logic                    clk,
  input logic                    RESETn,
  vga_gain_serializer_if.slave   bus
);

`ifdef VGA_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state, next_state;
  logic [3:0]       div_cnt;
  logic [4:0]       bit_cnt;
  logic             phase_hi;
  logic [NBITS-1:0] shreg;
  logic [5:0]       code_lat;
  logic [5:0]       applied_q;
  logic             div_last;

  logic [5:0]       diff10, diff20;
  logic [4:0]       vga1;
  logic [3:0]       vga2, vga3;
  logic [15:0]      payload;
  logic [NBITS-1:0] frame;

  assign div_last = (div_cnt == DIV_LAST);
  assign diff10   = bus.gain_code - 6'd10;
  assign diff20   = bus.gain_code - 6'd20;

  // Gain ladder: vga3 fills first, then vga2, then vga1, saturating at code 38.
  always_comb begin
    vga1 = '0;
    vga2 = '0;
    vga3 = '0;
    if (bus.gain_code < 6'd10) begin
      vga3 = bus.gain_code[3:0];
    end else if (bus.gain_code < 6'd20) begin
      vga2 = diff10[3:0];
      vga3 = 4'd10;
    end else if (bus.gain_code < 6'd39) begin
      vga1 = diff20[4:0];
      vga2 = 4'd10;
      vga3 = 4'd10;
    end else begin
      vga1 = 5'd18;
      vga2 = 4'd10;
      vga3 = 4'd10;
    end
  end

  assign payload = {HEADER, vga1, vga2, vga3};
`ifdef VGA_PARITY_EN
  assign frame = {payload, ^payload};
`else
  assign frame = payload;
`endif

  always_ff @(posedge clk) begin
    if (!RESETn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.gain_valid) next_state = SHIFT;
      SHIFT: if (div_last && phase_hi && bit_cnt == BIT_LAST) next_state = HOLD;
      HOLD:  if (div_last) next_state = GAP;
      GAP:   if (div_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit advance happens on the sclk high-to-low step, so data only moves while sclk is low.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase_hi  <= 1'b0;
      shreg     <= '0;
      code_lat  <= '0;
      applied_q <= 6'd63;
    end else begin
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          bit_cnt  <= '0;
          phase_hi <= 1'b0;
          if (bus.gain_valid) begin
            shreg    <= frame;
            code_lat <= bus.gain_code;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt  <= '0;
            phase_hi <= ~phase_hi;
            if (phase_hi && bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[NBITS-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        default: begin
          phase_hi <= 1'b0;
          div_cnt  <= div_last ? 4'd0 : div_cnt + 4'd1;
          if (state == GAP && div_last) applied_q <= code_lat;
        end
      endcase
    end
  end

  always_comb begin
    bus.gain_ready   = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.spi_sclk     = (state == SHIFT) && phase_hi;
    bus.spi_sen_n    = !((state == SHIFT) || (state == HOLD));
    bus.spi_sdata    = ((state == SHIFT) || (state == HOLD)) ? shreg[NBITS-1] : 1'b0;
    bus.frame_done   = (state == GAP) && div_last;
    bus.applied_gain = applied_q;
  end

endmodule

// File: tb/tb_vga_gain_serializer.sv
// Self-checking bench for vga_gain_serializer: random and directed gain codes against
// an arithmetic model of the gain ladder and frame timing.
module tb_vga_gain_serializer;

  localparam int DIV = 2;
`ifdef VGA_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif
  localparam int DONE_CYC = 2*DIV*NBITS + 2*DIV;

  logic clk = 1'b0;
  logic RESETn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   cap_bits, cap_n, cap_done, cap_done_cnt, cap_ready, cap_unstable;
  logic cap_first_ok, cap_first_sdata;

  vga_gain_serializer_if bus();

  vga_gain_serializer #(.DIV(DIV), .HEADER(3'b101)) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int model_frame(input int code);
    int v1, v2, v3, f;
    if (code < 10)      begin v1 = 0;         v2 = 0;         v3 = code; end
    else if (code < 20) begin v1 = 0;         v2 = code - 10; v3 = 10;   end
    else if (code < 39) begin v1 = code - 20; v2 = 10;        v3 = 10;   end
    else                begin v1 = 18;        v2 = 10;        v3 = 10;   end
    f = 5 * 8192 + v1 * 256 + v2 * 16 + v3;
`ifdef VGA_PARITY_EN
    begin
      int ones;
      ones = 0;
      for (int i = 0; i < 16; i++) ones += (f >> i) & 1;
      f = f * 2 + (ones % 2);
    end
`endif
    return f;
  endfunction

  // Launch one transfer and record what the serial pins carried until ready returns.
  task automatic run_frame(input int code);
    logic prev_sclk, cur_bit;
    cap_bits = 0; cap_n = 0; cap_done = -1; cap_done_cnt = 0; cap_ready = -1;
    cap_unstable = 0; cap_first_ok = 1'b0; cap_first_sdata = 1'b0;
    prev_sclk = 1'b0; cur_bit = 1'b0;
    @(negedge clk);
    bus.gain_code  = 6'(code);
    bus.gain_valid = 1'b1;
    @(posedge clk);
    #1 bus.gain_valid = 1'b0;
    for (int n = 1; n <= 400 && cap_ready < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cap_first_ok    = (bus.spi_sen_n === 1'b0) && (bus.busy === 1'b1) &&
                          (bus.spi_sclk === 1'b0) && (bus.gain_ready === 1'b0);
        cap_first_sdata = bus.spi_sdata;
      end
      if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        cap_bits = cap_bits * 2 + int'(bus.spi_sdata);
        cap_n++;
        cur_bit = bus.spi_sdata;
      end else if (bus.spi_sclk === 1'b1 && bus.spi_sdata !== cur_bit) begin
        cap_unstable++;
      end
      prev_sclk = bus.spi_sclk;
      if (bus.frame_done === 1'b1) begin
        cap_done_cnt++;
        if (cap_done < 0) cap_done = n;
      end
      if (bus.gain_ready === 1'b1) cap_ready = n;
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.gain_ready, bus.spi_sen_n, bus.spi_sclk, bus.spi_sdata, bus.busy, bus.frame_done} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got ready/sen_n/sclk/sdata/busy/done=%b expected 110000",
               {bus.gain_ready, bus.spi_sen_n, bus.spi_sclk, bus.spi_sdata, bus.busy, bus.frame_done});
    end
    checks++;
    if (bus.applied_gain !== 6'd63) begin
      errors++;
      $display("[TB] FAIL reset_applied: got %0d expected 63", bus.applied_gain);
    end
    RESETn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gain_ready, bus.spi_sen_n, bus.spi_sclk, bus.frame_done} !== 4'b1100 ||
          bus.applied_gain !== 6'd63) begin
        errors++;
        $display("[TB] FAIL idle_hold cycle %0d: got ready/sen_n/sclk/done=%b applied=%0d expected 1100 applied=63",
                 i, {bus.gain_ready, bus.spi_sen_n, bus.spi_sclk, bus.frame_done}, bus.applied_gain);
      end
    end
  endtask

  task automatic test_single_frame();
    int exp;
    exp = model_frame(25);
    run_frame(25);
    checks++;
    if (cap_bits !== exp) begin errors++; $display("[TB] FAIL frame25_bits: got %h expected %h", cap_bits, exp); end
    checks++;
    if (cap_n !== NBITS) begin errors++; $display("[TB] FAIL frame25_edges: got %0d expected %0d", cap_n, NBITS); end
    checks++;
    if (cap_done !== DONE_CYC || cap_done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL frame25_done: got cycle %0d count %0d expected cycle %0d count 1", cap_done, cap_done_cnt, DONE_CYC);
    end
    checks++;
    if (cap_ready !== DONE_CYC + 1) begin errors++; $display("[TB] FAIL frame25_ready: got %0d expected %0d", cap_ready, DONE_CYC + 1); end
    checks++;
    if (!cap_first_ok || cap_first_sdata !== 1'(exp >> (NBITS - 1))) begin
      errors++;
      $display("[TB] FAIL frame25_first_cycle: got ok=%0b sdata=%b expected ok=1 sdata=%0d", cap_first_ok, cap_first_sdata, exp >> (NBITS - 1));
    end
    checks++;
    if (cap_unstable !== 0) begin errors++; $display("[TB] FAIL frame25_stable: got %0d changes while sclk high expected 0", cap_unstable); end
    checks++;
    if (bus.applied_gain !== 6'd25 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame25_applied: got applied=%0d busy=%b expected 25 busy=0", bus.applied_gain, bus.busy);
    end
  endtask

  task automatic test_mapping();
    int codes[12];
    int exp;
    codes = '{0, 9, 10, 19, 20, 38, 39, 63, 0, 0, 0, 0};
    for (int i = 8; i < 12; i++) codes[i] = int'($urandom_range(0, 63));
    for (int i = 0; i < 12; i++) begin
      exp = model_frame(codes[i]);
      run_frame(codes[i]);
      checks++;
      if (cap_bits !== exp || cap_n !== NBITS) begin
        errors++;
        $display("[TB] FAIL map_code%0d: got %h (%0d bits) expected %h (%0d bits)", codes[i], cap_bits, cap_n, exp, NBITS);
      end
      checks++;
      if (bus.applied_gain !== 6'(codes[i]) || cap_done !== DONE_CYC) begin
        errors++;
        $display("[TB] FAIL map_applied%0d: got applied=%0d done=%0d expected applied=%0d done=%0d",
                 codes[i], bus.applied_gain, cap_done, codes[i], DONE_CYC);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   windows, second_start, early_ready;
    int   fb[2];
    logic prev_sen, prev_sclk, drop;
    windows = 0; second_start = -1; early_ready = 0;
    fb = '{0, 0};
    prev_sen = 1'b1; prev_sclk = 1'b0; drop = 1'b0;
    @(negedge clk);
    bus.gain_code  = 6'd30;
    bus.gain_valid = 1'b1;
    @(posedge clk);
    #1 bus.gain_valid = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (bus.spi_sen_n === 1'b0 && prev_sen === 1'b1) begin
        windows++;
        if (windows == 2) second_start = n;
      end
      if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0 && windows >= 1 && windows <= 2)
        fb[windows-1] = fb[windows-1] * 2 + int'(bus.spi_sdata);
      prev_sen  = bus.spi_sen_n;
      prev_sclk = bus.spi_sclk;
      if (n < DONE_CYC + 1 && bus.gain_ready === 1'b1) early_ready++;
      if (drop) begin bus.gain_valid = 1'b0; drop = 1'b0; end
      if (n == 5) begin bus.gain_code = 6'd5; bus.gain_valid = 1'b1; end
      if (bus.gain_valid && bus.gain_ready === 1'b1) drop = 1'b1;
    end
    bus.gain_valid = 1'b0;
    checks++;
    if (windows !== 2) begin errors++; $display("[TB] FAIL b2b_windows: got %0d expected 2", windows); end
    checks++;
    if (second_start !== DONE_CYC + 2) begin errors++; $display("[TB] FAIL b2b_second_start: got %0d expected %0d", second_start, DONE_CYC + 2); end
    checks++;
    if (early_ready !== 0) begin errors++; $display("[TB] FAIL b2b_early_ready: got %0d cycles expected 0", early_ready); end
    checks++;
    if (fb[0] !== model_frame(30)) begin errors++; $display("[TB] FAIL b2b_frame30: got %h expected %h", fb[0], model_frame(30)); end
    checks++;
    if (fb[1] !== model_frame(5) || ((fb[1] >> (NBITS - 16)) & 15) !== 5) begin
      errors++;
      $display("[TB] FAIL b2b_frame5: got %h expected %h with vga3=5", fb[1], model_frame(5));
    end
    checks++;
    if (bus.applied_gain !== 6'd5) begin errors++; $display("[TB] FAIL b2b_applied: got %0d expected 5", bus.applied_gain); end
  endtask

  task automatic test_reset_midframe();
    int   rises, stray_done, stray_sen, code;
    logic prev_sclk;
    rises = 0; stray_done = 0; stray_sen = 0; prev_sclk = 1'b0;
    @(negedge clk);
    bus.gain_code  = 6'd12;
    bus.gain_valid = 1'b1;
    @(posedge clk);
    #1 bus.gain_valid = 1'b0;
    for (int n = 1; n <= 200 && rises < 8; n++) begin
      @(negedge clk);
      if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = bus.spi_sclk;
    end
    checks++;
    if (rises !== 8) begin errors++; $display("[TB] FAIL abort_reach_bit7: got %0d rising edges expected 8", rises); end
    RESETn = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.spi_sen_n, bus.spi_sclk, bus.busy} !== 3'b100 || bus.applied_gain !== 6'd63) begin
      errors++;
      $display("[TB] FAIL abort_state: got sen_n/sclk/busy=%b applied=%0d expected 100 applied=63",
               {bus.spi_sen_n, bus.spi_sclk, bus.busy}, bus.applied_gain);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) stray_done++;
    end
    RESETn = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) stray_done++;
      if (bus.spi_sen_n !== 1'b1) stray_sen++;
    end
    checks++;
    if (stray_done !== 0 || stray_sen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got %0d done pulses %0d sen_n low cycles expected 0 0", stray_done, stray_sen);
    end
    code = int'($urandom_range(0, 62));
    run_frame(code);
    checks++;
    if (cap_bits !== model_frame(code) || cap_done !== DONE_CYC || bus.applied_gain !== 6'(code)) begin
      errors++;
      $display("[TB] FAIL abort_recover: got %h done=%0d applied=%0d expected %h done=%0d applied=%0d",
               cap_bits, cap_done, bus.applied_gain, model_frame(code), DONE_CYC, code);
    end
  endtask

  task automatic test_random();
    int code;
    for (int i = 0; i < 6; i++) begin
      code = int'($urandom_range(0, 63));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(code);
      checks++;
      if (cap_bits !== model_frame(code) || cap_ready !== DONE_CYC + 1 || cap_unstable !== 0) begin
        errors++;
        $display("[TB] FAIL rand_code%0d: got %h ready=%0d unstable=%0d expected %h ready=%0d unstable=0",
                 code, cap_bits, cap_ready, cap_unstable, model_frame(code), DONE_CYC + 1);
      end
      checks++;
      if (bus.applied_gain !== 6'(code)) begin
        errors++;
        $display("[TB] FAIL rand_applied%0d: got %0d expected %0d", code, bus.applied_gain, code);
      end
    end
  endtask

  initial begin
    bus.gain_code  = 6'd0;
    bus.gain_valid = 1'b0;
    $display("[TB] starting vga_gain_serializer bench, DIV=%0d NBITS=%0d", DIV, NBITS);
    test_reset();
    test_single_frame();
    test_mapping();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
